// File: rtl/mem_din_capture_if.sv
// Bus bundle between the CPU-side requester and the memory-read capture block.
// The master side issues requests and models the external 8-bit data path.
// The slave side is the capture block itself.
interface mem_din_capture_if;
    logic        start;
    logic        word;
    logic [15:0] addr;
    logic        mem_wait;
    logic [7:0]  mem_din;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  reg_mem_din_lo;
    logic [7:0]  reg_mem_din_hi;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, word, addr, mem_wait, mem_din,
        input  mem_rd, mem_addr, reg_mem_din_lo, reg_mem_din_hi, busy, done, err
    );

    modport slave (
        input  start, word, addr, mem_wait, mem_din,
        output mem_rd, mem_addr, reg_mem_din_lo, reg_mem_din_hi, busy, done, err
    );
endinterface

// File: rtl/mem_din_capture.sv
// Memory-read sequencer and data-in capture register.
// A start pulse performs one or two byte reads on the 8-bit external path and
// captures them into a zero-extended 16-bit operand for the internal bus.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no read in progress, waiting for start
// LO    | reading low byte at mem_addr, counting mem_wait stalls
// HI    | reading high byte at mem_addr (start address + 1)
// DONE  | one-cycle completion pulse; start here chains the next read
// ERR   | one-cycle timeout pulse; start here chains the next read
module mem_din_capture #(
    parameter int MAX_WAIT = 255
) (
    input logic              clk,
    input logic              rst,
    mem_din_capture_if.slave bus
);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WCNT_MAX = WW'(MAX_WAIT);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LO   = 3'd1,
        S_HI   = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [WW-1:0] wcnt;
    logic          word_q;
    logic [15:0]   addr_q;
    logic [7:0]    lo_q;
    logic [7:0]    hi_q;
    logic          accept;
    logic          wait_tc;

    // A new request is taken only when no byte read is in flight.
    assign accept  = bus.start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
    // Stall has already lasted MAX_WAIT cycles; one more aborts the byte.
    assign wait_tc = bus.mem_wait && (wcnt == WCNT_MAX);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = S_LO;
            end
            S_DONE, S_ERR: begin
                state_nxt = accept ? S_LO : S_IDLE;
            end
            S_LO: begin
                if (!bus.mem_wait) state_nxt = word_q ? S_HI : S_DONE;
                else if (wait_tc)  state_nxt = S_ERR;
            end
            S_HI: begin
                if (!bus.mem_wait) state_nxt = S_DONE;
                else if (wait_tc)  state_nxt = S_ERR;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request latch, address sequencing, stall counter and byte capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt   <= '0;
            word_q <= 1'b0;
            addr_q <= 16'h0000;
            lo_q   <= 8'h00;
            hi_q   <= 8'h00;
        end else begin
            if (accept) begin
                word_q <= bus.word;
                addr_q <= bus.addr;
                wcnt   <= '0;
                // Byte reads present a zero-extended operand from the start.
                if (!bus.word) hi_q <= 8'h00;
            end else if (state == S_LO) begin
                if (!bus.mem_wait) begin
                    lo_q <= bus.mem_din;
                    wcnt <= '0;
                    if (word_q) addr_q <= addr_q + 16'd1;
                end else if (!wait_tc) begin
                    wcnt <= wcnt + WW'(1);
                end
            end else if (state == S_HI) begin
                if (!bus.mem_wait) begin
                    hi_q <= bus.mem_din;
                    wcnt <= '0;
                end else if (!wait_tc) begin
                    wcnt <= wcnt + WW'(1);
                end
            end
        end
    end

    // Outputs are pure state decodes or registers.
    assign bus.mem_rd         = (state == S_LO) || (state == S_HI);
    assign bus.busy           = (state == S_LO) || (state == S_HI);
    assign bus.done           = (state == S_DONE);
    assign bus.err            = (state == S_ERR);
    assign bus.mem_addr       = addr_q;
    assign bus.reg_mem_din_lo = lo_q;
    assign bus.reg_mem_din_hi = hi_q;
endmodule

// File: doc/mem_din_capture.md
# mem_din_capture

Memory-read sequencer and data-in capture register for the CPU core; it produces `reg_mem_din_lo` / `reg_mem_din_hi`, the memory operand that the internal-bus multiplexer places on the 16-bit internal bus. On a one-cycle `start` it runs one or two byte reads on the 8-bit external data path and honours `mem_wait` stall cycles. It latches each byte, then reports completion, or a timeout error if the bus stalls too long. Byte reads are zero-extended so the captured pair is always a valid 16-bit operand.

## Interface
- `MAX_WAIT`, default 255: max consecutive `mem_wait` cycles tolerated per byte before abort; range 1..65535.
- `clk`  in  1  sole clock, all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  one-cycle request pulse; accepted only when `busy`=0
- `word`  in  1  sampled with `start`: 1 = 16-bit read (lo at `addr`, hi at `addr+1`), 0 = byte read
- `addr`  in  16  start address, sampled with `start`
- `mem_wait`  in  1  external stall, active-high; data not valid while 1
- `mem_din`  in  8  external read data
- `mem_rd`  out  1  read strobe, high during LO and HI states
- `mem_addr`  out  16  read address, registered
- `reg_mem_din_lo`  out  8  captured low byte
- `reg_mem_din_hi`  out  8  captured high byte (0x00 after byte read)
- `busy`  out  1  high in LO and HI states
- `done`  out  1  one-cycle pulse, read completed successfully
- `err`  out  1  one-cycle pulse, read aborted by wait timeout

## Operation
- States: IDLE, LO, HI, DONE, ERR. Wait counter `wcnt`, width `$clog2(MAX_WAIT+1)`.
- IDLE/DONE/ERR, `start`=1:
  - latch `word`; `mem_addr` <= `addr`; `wcnt` <= 0; go to LO.
  - If `word`=0, `reg_mem_din_hi` <= 0x00 on the same edge.
- DONE/ERR, `start`=0: go to IDLE.
- IDLE, `start`=0: stay.
- LO:
  - `mem_wait`=0: `reg_mem_din_lo` <= `mem_din`; `wcnt` <= 0; go to HI if `word`, else DONE.
  - In the same LO→HI transition, `mem_addr` <= `mem_addr`+1, mod 2^16 (0xFFFF wraps to 0x0000).
  - `mem_wait`=1 and `wcnt` < `MAX_WAIT`: `wcnt`++, stay.
  - `mem_wait`=1 and `wcnt` = `MAX_WAIT`: go to ERR. Capture registers keep their contents, except the zeroed hi byte of a byte read.
- HI: same rules as LO.
  - `mem_wait`=0: capture `mem_din` into `reg_mem_din_hi`, go to DONE.
  - Timeout goes to ERR; `reg_mem_din_lo` keeps its new value.
- `start` while `busy`=1 is ignored; there is no queueing.
- `mem_addr` holds its last value outside LO/HI. Capture registers hold until the next capture or reset.

## Timing
- Reset (async, immediate): state IDLE; `mem_rd`=0, `mem_addr`=0x0000, `reg_mem_din_lo`=0x00, `reg_mem_din_hi`=0x00, `busy`=0, `done`=0, `err`=0, `wcnt`=0.
- Reset mid-read aborts at once. No `done` or `err` is issued, and the first post-reset edge sees IDLE.
- All outputs are registered or decoded from state only; there is no combinational input→output path.
- Latency with no waits:
  - `start` sampled at edge N: LO during cycle N+1, lo captured at edge N+2.
  - Byte read: `done`=1 in cycle N+2.
  - Word read: HI in cycle N+2, hi captured at edge N+3, `done`=1 in cycle N+3.
- Each wait cycle adds exactly one cycle. A byte is aborted on the (`MAX_WAIT`+1)-th consecutive wait cycle, so `err` appears `MAX_WAIT`+1 cycles after entering the state.
- Captured bytes are visible on the outputs in the same cycle as `done`.
- Back-to-back: `start` during the DONE cycle begins the next read in the following cycle with no idle gap.

## Test plan
- Byte read, no wait: `addr`=0x1234, `word`=0, `mem_din`=0xA5 -> `mem_rd` high for 1 cycle at 0x1234; `done` 2 cycles after `start`; lo=0xA5, hi=0x00.
- Word read with waits: `addr`=0x2000, `word`=1; lo=0x34 after 2 waits, hi=0x12 after 0 waits -> `mem_addr` 0x2000 then 0x2001; `done` 5 cycles after `start`; {hi,lo}=0x1234.
- Wrap: `addr`=0xFFFF, `word`=1 -> second read at 0x0000; `done` pulses, no `err`.
- Timeout, `MAX_WAIT`=3: `mem_wait` held 1 in LO -> `err` after 4 LO cycles; no `done`; `busy` falls; lo unchanged.
- Ignored start and back-to-back:
  - `start` pulsed during HI -> ignored; exactly one `done`.
  - `start` during the DONE cycle -> next LO begins the next cycle.
- Async reset: assert `rst` mid-HI between edges -> outputs 0 immediately; neither `done` nor `err` pulses; a fresh read afterwards completes normally.
